sobel_edge_3x3: RTL and testbench

Downstream stage of the 5x5 Gaussian filter. Once the Gaussian pass has filled the destination image buffer, this block reads the 256x256 8-bit smoothed image through a buffer read port. It computes the 3x3 Sobel gradient magnitude per pixel and writes the result into a third image buffer through its write port. Control uses the same start/finish protocol as the filter stage, so a bench or sequencer can chain the two passes.

---
 rtl/img_pkg.sv | 27 ++
 rtl/sobel_edge_3x3_if.sv | 27 ++
 rtl/sobel_core.sv | 27 ++
 rtl/sobel_edge_3x3.sv | 147 ++++++++++++++
 tb/tb_sobel_edge_3x3.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/img_pkg.sv
// Shared image-buffer types: coordinate/pixel widths and the Sobel pass FSM states.
package img_pkg;

  localparam int unsigned CoordW = 10;
  localparam int unsigned PixW   = 8;
  localparam int unsigned AccW   = 12;

  typedef logic [CoordW-1:0] coord_t;
  typedef logic [PixW-1:0]   pix_t;

  typedef enum logic [2:0] {
    StIdle,
    StPrime,
    StPwait,
    StColRd,
    StColWait,
    StCalc,
    StWr,
    StDone
  } state_e;

  // Zero-extend a pixel into the signed gradient accumulator width.
  function automatic logic signed [AccW-1:0] widen(pix_t v);
    return $signed({{(AccW-PixW){1'b0}}, v});
  endfunction

endpackage

// File: rtl/sobel_edge_3x3_if.sv
// Source-buffer read port and destination-buffer write port of the Sobel pass.
interface sobel_edge_3x3_if;
  import img_pkg::*;

  logic   imgs_rd_en;
  coord_t imgs_rd_px;
  coord_t imgs_rd_py;
  pix_t   imgs_rd_dt;
  logic   imgs_rd_vl;
  logic   imgd_wr_en;
  coord_t imgd_wr_px;
  coord_t imgd_wr_py;
  pix_t   imgd_wr_dt;

  modport master (
    output imgs_rd_en, imgs_rd_px, imgs_rd_py,
    input  imgs_rd_dt, imgs_rd_vl,
    output imgd_wr_en, imgd_wr_px, imgd_wr_py, imgd_wr_dt
  );

  modport slave (
    input  imgs_rd_en, imgs_rd_px, imgs_rd_py,
    output imgs_rd_dt, imgs_rd_vl,
    input  imgd_wr_en, imgd_wr_px, imgd_wr_py, imgd_wr_dt
  );

endinterface

// File: rtl/sobel_core.sv
// Combinational 3x3 Sobel magnitude: |Gx|+|Gy|, right-shifted by SHIFT, saturated to 8 bits.
module sobel_core
  import img_pkg::*;
#(
  parameter int unsigned SHIFT = 0
) (
  input  pix_t [2:0][2:0] win,
  output pix_t            mag
);

  logic signed [AccW-1:0] gx, gy;
  logic        [AccW-1:0] ax, ay, sum, shifted;

  always_comb begin
    // win[r][c]: r is row (top to bottom), c is column (left to right)
    gx = (widen(win[0][2]) + (widen(win[1][2]) <<< 1) + widen(win[2][2]))
       - (widen(win[0][0]) + (widen(win[1][0]) <<< 1) + widen(win[2][0]));
    gy = (widen(win[2][0]) + (widen(win[2][1]) <<< 1) + widen(win[2][2]))
       - (widen(win[0][0]) + (widen(win[0][1]) <<< 1) + widen(win[0][2]));
    ax      = gx[AccW-1] ? -gx : gx;
    ay      = gy[AccW-1] ? -gy : gy;
    sum     = ax + ay;
    shifted = sum >> SHIFT;
    mag     = (shifted > AccW'(255)) ? 8'hFF : shifted[PixW-1:0];
  end

endmodule

// File: rtl/sobel_edge_3x3.sv
// Raster-scan Sobel pass: reads a 3x3 window per pixel from the source buffer and
// writes the saturated gradient magnitude to the destination buffer.
module sobel_edge_3x3
  import img_pkg::*;
#(
  parameter int unsigned SHIFT = 0,
  parameter int unsigned IMG_W = 256,
  parameter int unsigned IMG_H = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             finish,
  sobel_edge_3x3_if.master bus
);

  state_e          state_q, state_d;
  coord_t          x_q, y_q;
  logic [2:0]      iss_q, ret_q, ret_inc;
  pix_t [2:0][2:0] win_q, win_d;
  pix_t            mag_q, core_mag;
  logic            finish_q;
  logic            last_x, last_y, entering, issuing;
  logic [2:0]      prow;

  assign last_x   = (x_q == coord_t'(IMG_W - 1));
  assign last_y   = (y_q == coord_t'(IMG_H - 1));
  assign ret_inc  = ret_q + {2'b00, bus.imgs_rd_vl};
  assign issuing  = (state_q == StPrime) || (state_q == StColRd);
  assign entering = (state_d != state_q) && ((state_d == StPrime) || (state_d == StColRd));
  assign finish   = finish_q;

  sobel_core #(
    .SHIFT(SHIFT)
  ) u_core (
    .win(win_q),
    .mag(core_mag)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StPrime;
      StPrime:   if (iss_q == 3'd5) state_d = StPwait;
      StPwait:   if (ret_inc == 3'd6) state_d = StColRd;
      StColRd:   if (iss_q == 3'd2) state_d = StColWait;
      StColWait: if (ret_inc == 3'd3) state_d = StCalc;
      StCalc:    state_d = StWr;
      StWr:      state_d = last_x ? (last_y ? StDone : StPrime) : StColRd;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.imgs_rd_en = 1'b0;
    bus.imgs_rd_px = '0;
    bus.imgs_rd_py = '0;
    bus.imgd_wr_en = 1'b0;
    bus.imgd_wr_px = '0;
    bus.imgd_wr_py = '0;
    bus.imgd_wr_dt = '0;
    prow           = (iss_q >= 3'd3) ? iss_q - 3'd3 : iss_q;
    case (state_q)
      StPrime: begin
        // Issues 0..2 fetch column x-1, issues 3..5 fetch column x.
        bus.imgs_rd_en = 1'b1;
        bus.imgs_rd_px = (iss_q >= 3'd3) ? x_q : x_q - 10'd1;
        bus.imgs_rd_py = y_q + coord_t'(prow) - 10'd1;
      end
      StColRd: begin
        bus.imgs_rd_en = 1'b1;
        bus.imgs_rd_px = x_q + 10'd1;
        bus.imgs_rd_py = y_q + coord_t'(iss_q) - 10'd1;
      end
      StWr: begin
        bus.imgd_wr_en = 1'b1;
        bus.imgd_wr_px = x_q;
        bus.imgd_wr_py = y_q;
        bus.imgd_wr_dt = mag_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    win_d = win_q;
    if (state_q == StWr && state_d == StColRd) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
    end
    // Returns land in slots by arrival order, independent of what is being issued.
    if (bus.imgs_rd_vl) begin
      if ((state_q == StPrime || state_q == StPwait) && ret_q < 3'd6) begin
        if (ret_q < 3'd3) win_d[ret_q[1:0]][0] = bus.imgs_rd_dt;
        else              win_d[prow_of(ret_q)][1] = bus.imgs_rd_dt;
      end else if ((state_q == StColRd || state_q == StColWait) && ret_q < 3'd3) begin
        win_d[ret_q[1:0]][2] = bus.imgs_rd_dt;
      end
    end
  end

  function automatic logic [1:0] prow_of(logic [2:0] idx);
    logic [2:0] t;
    t = idx - 3'd3;
    return t[1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      iss_q    <= '0;
      ret_q    <= '0;
      win_q    <= '0;
      mag_q    <= '0;
      finish_q <= 1'b0;
    end else begin
      win_q <= win_d;
      iss_q <= entering ? 3'd0 : (issuing ? iss_q + 3'd1 : iss_q);
      ret_q <= entering ? 3'd0 : ret_inc;
      if (state_q == StCalc) mag_q <= core_mag;
      if (state_q == StIdle && start) begin
        finish_q <= 1'b0;
        x_q      <= '0;
        y_q      <= '0;
      end
      if (state_q == StWr) begin
        if (last_x) begin
          x_q <= '0;
          y_q <= last_y ? '0 : y_q + 10'd1;
          if (last_y) finish_q <= 1'b1;
        end else begin
          x_q <= x_q + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_edge_3x3.sv
// Bench for sobel_edge_3x3 on a small image: two instances (SHIFT 0 and 3) share one
// clamping image buffer with adjustable read latency; outputs checked against a kernel model.
module tb_sobel_edge_3x3;
  localparam int W = 16;
  localparam int H = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic finish0, finish1;

  always #5 clk = ~clk;

  sobel_edge_3x3_if bus0 ();
  sobel_edge_3x3_if bus1 ();

  sobel_edge_3x3 #(.SHIFT(0), .IMG_W(W), .IMG_H(H)) dut0 (
    .clk(clk), .rst(rst), .start(start), .finish(finish0), .bus(bus0)
  );
  sobel_edge_3x3 #(.SHIFT(3), .IMG_W(W), .IMG_H(H)) dut1 (
    .clk(clk), .rst(rst), .start(start), .finish(finish1), .bus(bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 1;
  int cyc      = 0;
  logic [7:0] img [H][W];
  int got0 [H][W];
  int got1 [H][W];

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Buffer model: coordinates outside the image replicate the nearest edge pixel.
  function automatic int pix(int x, int y);
    int cx, cy;
    cx = (x < 0) ? 0 : (x >= W) ? W - 1 : x;
    cy = (y < 0) ? 0 : (y >= H) ? H - 1 : y;
    return int'(img[cy][cx]);
  endfunction

  function automatic int model(int x, int y, int sh);
    int kx [9];
    int ky [9];
    int gx, gy, v, m;
    kx = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    ky = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    gx = 0;
    gy = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        v  = pix(x - 1 + c, y - 1 + r);
        gx += kx[r*3+c] * v;
        gy += ky[r*3+c] * v;
      end
    end
    m = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
    m = m >> sh;
    return (m > 255) ? 255 : m;
  endfunction

  // Read-return pipeline; both instances issue identical reads, so dut0's drive it.
  logic       vpipe [8];
  logic [7:0] dpipe [8];
  always @(posedge clk) begin
    for (int i = 7; i > 0; i--) begin
      vpipe[i] <= vpipe[i-1];
      dpipe[i] <= dpipe[i-1];
    end
    vpipe[0] <= bus0.imgs_rd_en;
    dpipe[0] <= 8'(pix(int'($signed(bus0.imgs_rd_px)), int'($signed(bus0.imgs_rd_py))));
    cyc <= cyc + 1;
  end
  assign bus0.imgs_rd_vl = vpipe[lat-1];
  assign bus0.imgs_rd_dt = dpipe[lat-1];
  assign bus1.imgs_rd_vl = vpipe[lat-1];
  assign bus1.imgs_rd_dt = dpipe[lat-1];

  int   exp_x = 0, exp_y = 0, n_wr = 0, last_wr = 0, fin_rises = 0;
  logic fin_prev = 1'b0, chk_fin_next = 1'b0, abort_mode = 1'b0;

  always @(negedge clk) begin
    if (finish0 && !fin_prev) fin_rises++;
    fin_prev = finish0;
    if (chk_fin_next) begin
      check("finish after last write", int'(finish0), 1);
      chk_fin_next = 1'b0;
    end
    if (abort_mode) begin
      check("write after reset", int'(bus0.imgd_wr_en), 0);
      check("read after reset", int'(bus0.imgs_rd_en), 0);
    end else if (bus0.imgd_wr_en) begin
      check("write coord", int'(bus0.imgd_wr_py) * 1024 + int'(bus0.imgd_wr_px),
            exp_y * 1024 + exp_x);
      check("data shift0", int'(bus0.imgd_wr_dt), model(exp_x, exp_y, 0));
      check("dut1 write en", int'(bus1.imgd_wr_en), 1);
      check("data shift3", int'(bus1.imgd_wr_dt), model(exp_x, exp_y, 3));
      check("finish low during pass", int'(finish0), 0);
      if (exp_x != 0) check("pixel interval", cyc - last_wr, 5 + lat);
      last_wr = cyc;
      if (exp_y < H) begin
        got0[exp_y][exp_x] = int'(bus0.imgd_wr_dt);
        got1[exp_y][exp_x] = int'(bus1.imgd_wr_dt);
      end
      n_wr++;
      if (exp_x == W - 1 && exp_y == H - 1) chk_fin_next = 1'b1;
      if (exp_x == W - 1) begin
        exp_x = 0;
        exp_y++;
      end else begin
        exp_x++;
      end
    end
  end

  task automatic load_image(int kind);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        case (kind)
          0:       img[y][x] = 8'h80;
          1:       img[y][x] = (x < W / 2) ? 8'd0 : 8'd255;
          default: img[y][x] = (x == 10 && y == 10) ? 8'd100 : 8'd0;
        endcase
      end
    end
  endtask

  task automatic clear_tracking();
    exp_x     = 0;
    exp_y     = 0;
    n_wr      = 0;
    fin_rises = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_pass(int l, string tag);
    int done;
    lat = l;
    clear_tracking();
    pulse_start();
    done = 0;
    for (int i = 0; i < 10000 && done == 0; i++) begin
      @(negedge clk);
      if (finish0) done = 1;
    end
    check({tag, " finish reached"}, done, 1);
    repeat (3) @(negedge clk);
    check({tag, " write count"}, n_wr, W * H);
    check({tag, " finish rises"}, fin_rises, 1);
    check({tag, " finish held"}, int'(finish0), 1);
  endtask

  function automatic int outs_nonzero();
    return int'(|{bus0.imgs_rd_en, bus0.imgs_rd_px, bus0.imgs_rd_py, bus0.imgd_wr_en,
                  bus0.imgd_wr_px, bus0.imgd_wr_py, bus0.imgd_wr_dt, finish0,
                  bus1.imgs_rd_en, bus1.imgd_wr_en, bus1.imgd_wr_dt, finish1});
  endfunction

  initial begin
    int hit;
    load_image(0);
    repeat (10) @(negedge clk);
    check("reset outputs", outs_nonzero(), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle outputs", outs_nonzero(), 0);

    run_pass(1, "const");
    check("const (5,5)", got0[5][5], 0);

    load_image(1);
    run_pass(1, "step");
    check("step x=7 shift0", got0[6][7], 255);
    check("step x=8 shift0", got0[6][8], 255);
    check("step x=3 shift0", got0[6][3], 0);
    check("step x=7 shift3", got1[6][7], 127);
    check("step top row shift3", got1[0][8], 127);

    load_image(2);
    run_pass(1, "dot");
    check("dot (10,10)", got0[10][10], 0);
    check("dot (11,10)", got0[10][11], 200);
    check("dot (11,11)", got0[11][11], 200);
    check("dot (9,9)", got0[9][9], 200);
    check("dot (11,10) shift3", got1[10][11], 25);

    load_image(1);
    run_pass(3, "step lat3");
    check("step lat3 x=8 shift3", got1[6][8], 127);

    // Abort mid-pass at pixel (5,4), then a clean pass.
    lat = 1;
    clear_tracking();
    pulse_start();
    hit = 0;
    for (int i = 0; i < 5000 && hit == 0; i++) begin
      @(negedge clk);
      if (bus0.imgd_wr_en && bus0.imgd_wr_px == 10'd5 && bus0.imgd_wr_py == 10'd4) hit = 1;
    end
    check("reached abort pixel", hit, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("outputs after reset", outs_nonzero(), 0);
    abort_mode = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("finish after abort", int'(finish0), 0);
    abort_mode = 1'b0;
    run_pass(2, "after abort");
    check("after abort x=8", got0[3][8], 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
